// File: rtl/dnn_param_loader_pkg.sv
// Shared constants and types for the dnn parameter loader.
//   DW/N_IN/N_HID/N_OUT : network geometry of the 4-4-2 datapath
//   N_W1/N_W2/FRAME_LEN : derived weight counts and full frame length
//   ldr_state_t         : loader FSM states
//   word_t              : one signed stream word
package dnn_pkg;
  localparam int DW        = 5;
  localparam int N_IN      = 4;
  localparam int N_HID     = 4;
  localparam int N_OUT     = 2;
  localparam int N_W1      = N_IN * N_HID;
  localparam int N_W2      = N_HID * N_OUT;
  localparam int FRAME_LEN = N_IN + N_W1 + N_W2;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} ldr_state_t;
  typedef logic signed [DW-1:0] word_t;
endpackage

// File: rtl/dnn_param_loader_if.sv
// Word stream into the loader.
//   s_data   : signed word         s_valid : word present
//   s_last   : final word of frame s_x_only: inputs-only frame (first word)
//   s_ready  : loader accepts (transfer = s_valid & s_ready)
interface dnn_param_loader_if;
  dnn_pkg::word_t s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_x_only;
  logic           s_ready;

  modport master (output s_data, s_valid, s_last, s_x_only, input s_ready);
  modport slave  (input s_data, s_valid, s_last, s_x_only, output s_ready);
endinterface

// File: rtl/dnn_ldr_slot_decode.sv
// Frame index -> one-hot operand slot write enable.
//   idx_i : word index within frame   en_i : write this cycle
//   we_o  : one bit per operand slot
module dnn_ldr_slot_decode
  import dnn_pkg::*;
(
  input  logic [CNT_W-1:0]     idx_i,
  input  logic                 en_i,
  output logic [FRAME_LEN-1:0] we_o
);
  for (genvar k = 0; k < FRAME_LEN; k++) begin : g_slot
    assign we_o[k] = en_i && (idx_i == CNT_W'(k));
  end
endmodule

// File: rtl/dnn_param_loader.sv
// Assembles x / layer-1 / layer-2 operands from a word stream, launches the
// dnn with a one-cycle in_ready and waits for both output completions.
//   clk, rst_n          : clock, async active-low reset
//   s                   : word stream (slave side)
//   x_flat/w1_flat/w2_flat : operand buses, stable while busy
//   in_ready            : launch pulse      out10/11_ready : completion
//   weights_vld, busy   : status            frame_err, timeout_err : pulses
module dnn_param_loader
  import dnn_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dnn_param_loader_if.slave    s,
  output logic [N_IN*DW-1:0]   x_flat,
  output logic [N_W1*DW-1:0]   w1_flat,
  output logic [N_W2*DW-1:0]   w2_flat,
  output logic                 in_ready,
  input  logic                 out10_ready,
  input  logic                 out11_ready,
  output logic                 weights_vld,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 timeout_err
);
  localparam int TMR_W = $clog2(WAIT_MAX + 1);

  ldr_state_t                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [TMR_W-1:0]            tmr_q, tmr_d;
  logic                        mode_q, mode_d;   // 1 = x-only frame
  logic                        wvld_q, wvld_d;
  logic                        ferr_q, ferr_d;
  logic [FRAME_LEN-1:0][DW-1:0] slot_q;
  logic [FRAME_LEN-1:0]        we;

  logic             rdy, xfer, done, cur_mode, wr_en;
  logic [CNT_W-1:0] cur_idx, last_idx;

  dnn_ldr_slot_decode u_dec (.idx_i(cur_idx), .en_i(wr_en), .we_o(we));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    mode_d      = mode_q;
    wvld_d      = wvld_q;
    ferr_d      = 1'b0;
    in_ready    = 1'b0;
    timeout_err = 1'b0;
    wr_en       = 1'b0;
    done        = out10_ready & out11_ready;
    // Gate with rst_n so the stream sees not-ready during reset.
    rdy         = rst_n && (state_q == IDLE || state_q == LOAD);
    xfer        = s.s_valid & rdy;
    // First word of a frame decides the mode; stored weights are required.
    cur_mode    = (state_q == IDLE) ? (s.s_x_only & wvld_q) : mode_q;
    cur_idx     = (state_q == IDLE) ? '0 : cnt_q;
    last_idx    = cur_mode ? CNT_W'(N_IN - 1) : CNT_W'(FRAME_LEN - 1);

    case (state_q)
      IDLE, LOAD: begin
        if (xfer) begin
          wr_en  = 1'b1;
          mode_d = cur_mode;
          if (cur_idx == last_idx && s.s_last) begin
            state_d = FIRE;
            cnt_d   = '0;
            if (!cur_mode) wvld_d = 1'b1;
          end else if (cur_idx == last_idx || s.s_last) begin
            // Misplaced s_last: a full frame has already overwritten weights.
            state_d = IDLE;
            cnt_d   = '0;
            ferr_d  = 1'b1;
            if (!cur_mode) wvld_d = 1'b0;
          end else begin
            state_d = LOAD;
            cnt_d   = cur_idx + CNT_W'(1);
          end
        end
      end
      FIRE: begin
        in_ready = 1'b1;
        tmr_d    = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (done) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(WAIT_MAX)) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
          tmr_d       = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      mode_q  <= 1'b0;
      wvld_q  <= 1'b0;
      ferr_q  <= 1'b0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      mode_q  <= mode_d;
      wvld_q  <= wvld_d;
      ferr_q  <= ferr_d;
      for (int k = 0; k < FRAME_LEN; k++)
        if (we[k]) slot_q[k] <= s.s_data;
    end
  end

  assign s.s_ready   = rdy;
  assign x_flat      = slot_q[N_IN-1:0];
  assign w1_flat     = slot_q[N_IN+N_W1-1:N_IN];
  assign w2_flat     = slot_q[FRAME_LEN-1:N_IN+N_W1];
  assign weights_vld = wvld_q;
  assign busy        = (state_q == FIRE) || (state_q == WAIT);
  assign frame_err   = ferr_q;
endmodule

// File: tb/tb_dnn_param_loader.sv
module tb_dnn_param_loader;
  import dnn_pkg::*;
  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dnn_param_loader_if sif();
  logic [N_IN*DW-1:0] x_flat;
  logic [N_W1*DW-1:0] w1_flat;
  logic [N_W2*DW-1:0] w2_flat;
  logic in_ready, weights_vld, busy, frame_err, timeout_err;
  logic out10_ready = 1'b0;
  logic out11_ready = 1'b0;

  dnn_param_loader #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .s(sif),
    .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
    .in_ready(in_ready), .out10_ready(out10_ready), .out11_ready(out11_ready),
    .weights_vld(weights_vld), .busy(busy),
    .frame_err(frame_err), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference: the operand slot contents, addressed by word position in frame.
  logic [DW-1:0] m_slot [FRAME_LEN];
  bit            m_wvld;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] m_flat(input int lo, input int n);
    logic [127:0] v = '0;
    for (int k = 0; k < n; k++) v[k*DW +: DW] = m_slot[lo+k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last, input bit xo);
    int b;
    b = $urandom_range(0, 2);
    repeat (b) begin
      sif.s_valid = 1'b0;
      sif.s_data  = DW'($urandom);
      sif.s_last  = 1'(($urandom));
      tick();
    end
    sif.s_data   = d;
    sif.s_last   = last;
    sif.s_x_only = xo;
    sif.s_valid  = 1'b1;
    #1 chk("s_ready_load", sif.s_ready, 1);
    tick();
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  // Sends up to n words with s_last at position last_at; the model applies
  // the frame rules and stops at the word that ends or breaks the frame.
  task automatic run_frame(input int n, input int last_at, input bit xo,
                           input bit directed, output bit fired);
    bit mode;
    int len;
    logic [DW-1:0] d;
    mode  = xo & m_wvld;
    len   = mode ? N_IN : FRAME_LEN;
    fired = 1'b0;
    for (int k = 0; k < n; k++) begin
      d = directed ? DW'((k < N_IN) ? k + 1 : 1) : DW'($urandom);
      send(d, k == last_at, xo);
      m_slot[k] = d;
      if (k == len - 1 || k == last_at) begin
        fired = (k == len - 1) && (k == last_at);
        if (!mode) m_wvld = fired;
        break;
      end
    end
  endtask

  task automatic check_ops(input string tag);
    chk({tag, "_x"},  x_flat,  m_flat(0, N_IN));
    chk({tag, "_w1"}, w1_flat, m_flat(N_IN, N_W1));
    chk({tag, "_w2"}, w2_flat, m_flat(N_IN + N_W1, N_W2));
    chk({tag, "_wvld"}, weights_vld, m_wvld);
  endtask

  // Called in the cycle after the final transfer; leaves us in WAIT cycle 0.
  task automatic check_fire(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_s_ready"}, sif.s_ready, 0);
    check_ops(tag);
    tick();
    chk({tag, "_in_ready_1cyc"}, in_ready, 0);
    chk({tag, "_busy_wait"}, busy, 1);
  endtask

  task automatic check_err(input string tag);
    chk({tag, "_frame_err"}, frame_err, 1);
    chk({tag, "_no_fire"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wvld"}, weights_vld, m_wvld);
    tick();
    chk({tag, "_frame_err_1cyc"}, frame_err, 0);
    chk({tag, "_no_fire2"}, in_ready, 0);
  endtask

  task automatic complete(input string tag, input int dly);
    repeat (dly) tick();
    out10_ready = 1'b1;
    out11_ready = 1'b1;
    tick();
    out10_ready = 1'b0;
    out11_ready = 1'b0;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_ready"}, sif.s_ready, 1);
  endtask

  initial begin
    bit f;
    int seen;
    sif.s_data = '0; sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_x_only = 1'b0;
    m_wvld = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) m_slot[k] = '0;

    // Reset values
    #12;
    chk("rst_s_ready", sif.s_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {frame_err, timeout_err}, 0);
    check_ops("rst");
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rel_s_ready", sif.s_ready, 1);

    // 1: directed full frame, then stability while busy
    run_frame(FRAME_LEN, FRAME_LEN - 1, 1'b0, 1'b1, f);
    check_fire("t1");
    repeat (3) begin
      sif.s_valid = 1'b1;
      sif.s_data  = DW'($urandom);
      tick();
      chk("t1_hold_ready", sif.s_ready, 0);
      check_ops("t1_hold");
    end
    sif.s_valid = 1'b0;
    complete("t1", 2);

    // 2: x-only frame reuses weights
    run_frame(N_IN, N_IN - 1, 1'b1, 1'b0, f);
    check_fire("t2");
    complete("t2", 1);

    // 2b: x-only frame missing s_last keeps weights valid
    run_frame(N_IN, -1, 1'b1, 1'b0, f);
    check_err("t2b");
    check_ops("t2b");

    // 3: early s_last on word 10, then x-only request loads as full frame
    run_frame(FRAME_LEN, 10, 1'b0, 1'b0, f);
    check_err("t3");
    run_frame(FRAME_LEN, FRAME_LEN - 1, 1'b1, 1'b0, f);
    check_fire("t3_reload");
    complete("t3", 0);

    // 4: completion held low -> timeout after WAIT_MAX cycles in WAIT
    run_frame(N_IN, N_IN - 1, 1'b1, 1'b0, f);
    check_fire("t4");
    seen = -1;
    for (int c = 0; c < 40; c++) begin
      if (timeout_err) begin seen = c; break; end
      tick();
    end
    chk("t4_timeout_cycle", seen, WAIT_MAX);
    tick();
    chk("t4_timeout_1cyc", timeout_err, 0);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_ready", sif.s_ready, 1);
    check_ops("t4_after");

    // Completion on the timeout cycle wins
    run_frame(N_IN, N_IN - 1, 1'b1, 1'b0, f);
    check_fire("tsim");
    repeat (WAIT_MAX) tick();
    out10_ready = 1'b1;
    out11_ready = 1'b1;
    #1 chk("tsim_no_timeout", timeout_err, 0);
    tick();
    out10_ready = 1'b0;
    out11_ready = 1'b0;
    chk("tsim_idle", busy, 0);
    chk("tsim_no_timeout2", timeout_err, 0);

    // 5: only one completion high keeps WAIT
    run_frame(N_IN, N_IN - 1, 1'b1, 1'b0, f);
    check_fire("t5");
    out10_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("t5_still_wait", busy, 1);
    end
    out11_ready = 1'b1;
    tick();
    out10_ready = 1'b0;
    out11_ready = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_idle_ready", sif.s_ready, 1);

    // 6: reset mid-frame, then fresh full frame with bubbles
    run_frame(15, -1, 1'b0, 1'b0, f);
    #1 rst_n = 1'b0;
    m_wvld = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) m_slot[k] = '0;
    #1;
    chk("t6_rst_ready", sif.s_ready, 0);
    chk("t6_rst_busy", busy, 0);
    check_ops("t6_rst");
    tick();
    @(negedge clk) rst_n = 1'b1;
    run_frame(FRAME_LEN, FRAME_LEN - 1, 1'b0, 1'b0, f);
    check_fire("t6");
    complete("t6", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
